clean_reminder_timer: RTL and testbench
=======================================

# clean_reminder_timer

Generates the `warning` level consumed by the "CLEN" blinking display. It accumulates range-hood fan run time in seconds and raises `warning` once the cleaning threshold is reached. It clears the accumulated time only after a self-clean cycle has run uninterrupted to completion. It sits between the fan/mode controller (which supplies `fan_on` and `clean_active`) and the display path.

## Interface
Parameters:
- `TICK_DIV`, 500: `clk_500Hz` cycles per 1 s tick.
- `THRESH_SEC`, 36000: fan run seconds before `warning` asserts (10 h).
- `CLEAN_SEC`, 180: uninterrupted self-clean seconds required to clear usage.
- `SNOOZE_SEC`, 600: warning silence time; exists only with the snooze feature.
- `UW`, 17: width of `usage_sec`; must satisfy 2^UW-1 ≥ THRESH_SEC.

Ports:
- `clk_500Hz`, in, 1: system clock.
- `rst_n`, in, 1: reset; asynchronous, active-low.
- `fan_on`, in, 1: fan running (level, synchronous to the clock).
- `clean_active`, in, 1: self-clean mode running (level).
- `snooze`, in, 1: one-cycle snooze request; exists only with the snooze feature.
- `warning`, out, 1: cleaning needed; drives the display.
- `clean_busy`, out, 1: self-clean countdown in progress.
- `usage_sec`, out, UW: accumulated fan seconds.
- `clean_left`, out, 8: remaining self-clean seconds.

## Operation
- Tick prescaler:
  - Free-running, 0..TICK_DIV-1; `tick`=1 in the cycle the count equals TICK_DIV-1.
  - Not affected by state changes.
- States: ACCUM, WARN, CLEAN, plus SNOOZE when the feature is built in.
- Usage counting:
  - In ACCUM, WARN and SNOOZE: on `tick && fan_on`, `usage_sec` increments.
  - It saturates at 2^UW-1 and never wraps.
- ACCUM → WARN when `usage_sec` ≥ THRESH_SEC.
- ACCUM or WARN → CLEAN when `clean_active`=1. Voluntary cleaning is allowed before the threshold.
  - On entry, `clean_left` loads CLEAN_SEC.
- CLEAN:
  - On `tick`, `clean_left` decrements. `usage_sec` is frozen.
  - When a tick takes `clean_left` from 1 to 0: go to ACCUM and clear `usage_sec` to 0 on that same edge.
  - If `clean_active` drops: abort. Go to WARN if `usage_sec` ≥ THRESH_SEC, else ACCUM. Reload `clean_left`=0. `usage_sec` is kept.
  - If the completing tick and the `clean_active` drop occur in the same cycle, completion wins.
- Outputs:
  - `warning` = (state==WARN).
  - `clean_busy` = (state==CLEAN).
- Reset (any time, including mid-clean): state ACCUM, `warning`=0, `clean_busy`=0, `usage_sec`=0, `clean_left`=0, prescaler=0.

## Timing
- All state and counter updates happen on the rising edge of `clk_500Hz`.
- First tick occurs TICK_DIV cycles after reset release.
- `warning` rises one cycle after the edge where `usage_sec` reaches THRESH_SEC.
- `clean_active` is sampled each cycle; CLEAN is entered and `clean_busy` is high one cycle after `clean_active` is seen high.
- An abort takes effect one cycle after `clean_active` is seen low.
- `usage_sec` returns to 0 on the completing tick edge; `warning` stays low afterwards.

## Configuration
- `CLEAN_REMINDER_SNOOZE_EN` defined:
  - The `snooze` port, SNOOZE state and SNOOZE_SEC exist.
  - WARN + `snooze` → SNOOZE, with a snooze counter loaded to SNOOZE_SEC.
  - In SNOOZE: `warning`=0, usage keeps accumulating, and the counter decrements on tick.
  - When the counter reaches 0: → WARN.
  - `clean_active` in SNOOZE → CLEAN, with CLEAN taking priority over `snooze`.
  - `snooze` outside WARN is ignored.
- Macro undefined:
  - No `snooze` port and no SNOOZE state.
  - `warning` stays high until a completed clean.

## Structure
- Shared package `clean_pkg` holds:
  - The state enum/encoding (ACCUM=0, WARN=1, CLEAN=2, SNOOZE=3).
  - Default constants for TICK_DIV, THRESH_SEC, CLEAN_SEC and SNOOZE_SEC, reused by the display and the top level.
- Sub-module `sec_tick_gen`: parameterised prescaler producing the 1-cycle `tick`, reusable by the other timers.

## Test plan
All scenarios use TICK_DIV=4, THRESH_SEC=5, CLEAN_SEC=3, SNOOZE_SEC=2.
- Reset, hold `fan_on`=1 → `usage_sec` increments every 4 cycles. `warning` rises one cycle after `usage_sec`=5, i.e. at cycle 21.
- With `warning` high, assert `clean_active` for 3 ticks → `clean_busy` high, `clean_left` goes 3,2,1,0, then `usage_sec`=0, `warning`=0, state ACCUM.
- In WARN, start a clean, drop `clean_active` after 1 tick → `clean_busy`=0, `warning` back to 1, `usage_sec` unchanged (5+).
- `clean_active` drop coincides with the completing tick → treated as completion: `usage_sec`=0, `warning`=0.
- Assert `rst_n` low mid-CLEAN → all outputs 0 immediately (asynchronous); accumulation restarts from 0.
- (Only with `CLEAN_REMINDER_SNOOZE_EN`) In WARN, pulse `snooze` → `warning` low for 2 ticks while `usage_sec` still increments, then `warning` returns to 1.

Source files
------------

// File: rtl/clean_pkg.sv
// Shared definitions for the cleaning-reminder timers: FSM state encoding
// and default timing constants reused by the display and the top level.
package clean_pkg;

  typedef enum logic [1:0] {
    ACCUM  = 2'd0,
    WARN   = 2'd1,
    CLEAN  = 2'd2,
    SNOOZE = 2'd3
  } clean_state_t;

  localparam int DEF_TICK_DIV   = 500;
  localparam int DEF_THRESH_SEC = 36000;
  localparam int DEF_CLEAN_SEC  = 180;
  localparam int DEF_SNOOZE_SEC = 600;
  localparam int DEF_UW         = 17;

endpackage

// File: rtl/clean_reminder_timer_if.sv
// Signal bundle between the fan/mode controller, the reminder timer and the
// display path. The snooze request exists only with CLEAN_REMINDER_SNOOZE_EN.
interface clean_reminder_timer_if #(
  parameter int UW = 17
);
  logic          fan_on;
  logic          clean_active;
`ifdef CLEAN_REMINDER_SNOOZE_EN
  logic          snooze;
`endif
  logic          warning;
  logic          clean_busy;
  logic [UW-1:0] usage_sec;
  logic [7:0]    clean_left;

  modport master (
    output fan_on,
    output clean_active,
`ifdef CLEAN_REMINDER_SNOOZE_EN
    output snooze,
`endif
    input  warning,
    input  clean_busy,
    input  usage_sec,
    input  clean_left
  );

  modport slave (
    input  fan_on,
    input  clean_active,
`ifdef CLEAN_REMINDER_SNOOZE_EN
    input  snooze,
`endif
    output warning,
    output clean_busy,
    output usage_sec,
    output clean_left
  );
endinterface

// File: rtl/sec_tick_gen.sv
// Free-running prescaler: asserts tick for one cycle every TICK_DIV clocks,
// first tick TICK_DIV cycles after reset release.
module sec_tick_gen #(
  parameter int TICK_DIV = 500
) (
  input  logic clk_500Hz,
  input  logic rst_n,
  output logic tick
);
  localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk_500Hz or negedge rst_n) begin
    if (!rst_n)            cnt <= '0;
    else if (cnt == LAST)  cnt <= '0;
    else                   cnt <= cnt + 1'b1;
  end

  assign tick = (cnt == LAST);
endmodule

// File: rtl/clean_reminder_timer.sv
// Range-hood cleaning reminder: accumulates fan seconds, raises warning at the
// threshold, clears usage after an uninterrupted self-clean. Optional snooze
// support is built in when CLEAN_REMINDER_SNOOZE_EN is defined.
module clean_reminder_timer
  import clean_pkg::*;
#(
  parameter int TICK_DIV   = DEF_TICK_DIV,
  parameter int THRESH_SEC = DEF_THRESH_SEC,
  parameter int CLEAN_SEC  = DEF_CLEAN_SEC,
  parameter int UW         = DEF_UW
`ifdef CLEAN_REMINDER_SNOOZE_EN
  , parameter int SNOOZE_SEC = DEF_SNOOZE_SEC
`endif
) (
  input  logic                  clk_500Hz,
  input  logic                  rst_n,
  clean_reminder_timer_if.slave bus
);
  localparam logic [UW-1:0] THRESH_U = UW'(THRESH_SEC);
  localparam logic [7:0]    CLEAN_L  = 8'(CLEAN_SEC);

  clean_state_t  state_q;
  logic          warning_q;
  logic          busy_q;
  logic [UW-1:0] usage_q;
  logic [7:0]    left_q;
  logic          tick;
  logic          at_thresh;

`ifdef CLEAN_REMINDER_SNOOZE_EN
  localparam int            SW    = (SNOOZE_SEC > 1) ? $clog2(SNOOZE_SEC + 1) : 1;
  localparam logic [SW-1:0] SNZ_L = SW'(SNOOZE_SEC);
  logic [SW-1:0] snz_q;
`endif

  function automatic logic [UW-1:0] sat_inc(input logic [UW-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  sec_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk_500Hz (clk_500Hz),
    .rst_n     (rst_n),
    .tick      (tick)
  );

  assign at_thresh = (usage_q >= THRESH_U);

  // Outputs are registered alongside the state so they never glitch on the display.
  always_ff @(posedge clk_500Hz or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ACCUM;
      warning_q <= 1'b0;
      busy_q    <= 1'b0;
      usage_q   <= '0;
      left_q    <= '0;
`ifdef CLEAN_REMINDER_SNOOZE_EN
      snz_q     <= '0;
`endif
    end else begin
      case (state_q)
        CLEAN: begin
          // A completing tick beats a simultaneous clean_active drop.
          if (tick && left_q == 8'd1) begin
            state_q   <= ACCUM;
            warning_q <= 1'b0;
            busy_q    <= 1'b0;
            usage_q   <= '0;
            left_q    <= '0;
          end else if (!bus.clean_active) begin
            state_q   <= at_thresh ? WARN : ACCUM;
            warning_q <= at_thresh;
            busy_q    <= 1'b0;
            left_q    <= '0;
          end else if (tick) begin
            left_q    <= left_q - 8'd1;
          end
        end
        default: begin
          // ACCUM, WARN and SNOOZE all keep counting fan time.
          if (tick && bus.fan_on) usage_q <= sat_inc(usage_q);
          if (bus.clean_active) begin
            state_q   <= CLEAN;
            warning_q <= 1'b0;
            busy_q    <= 1'b1;
            left_q    <= CLEAN_L;
          end else if (state_q == ACCUM) begin
            if (at_thresh) begin
              state_q   <= WARN;
              warning_q <= 1'b1;
            end
          end
`ifdef CLEAN_REMINDER_SNOOZE_EN
          else if (state_q == WARN) begin
            if (bus.snooze) begin
              state_q   <= SNOOZE;
              warning_q <= 1'b0;
              snz_q     <= SNZ_L;
            end
          end else if (tick) begin
            snz_q <= snz_q - 1'b1;
            if (snz_q <= SW'(1)) begin
              state_q   <= WARN;
              warning_q <= 1'b1;
              snz_q     <= '0;
            end
          end
`endif
        end
      endcase
    end
  end

  assign bus.warning    = warning_q;
  assign bus.clean_busy = busy_q;
  assign bus.usage_sec  = usage_q;
  assign bus.clean_left = left_q;
endmodule

// File: tb/tb_clean_reminder_timer.sv
// Bench for clean_reminder_timer with TICK_DIV=4, THRESH_SEC=5, CLEAN_SEC=3,
// SNOOZE_SEC=2; a second narrow-usage instance exercises saturation.
module tb_clean_reminder_timer;
  logic clk_500Hz = 1'b0;
  logic rst_n     = 1'b0;
  int   checks    = 0;
  int   errors    = 0;

  always #5 clk_500Hz = ~clk_500Hz;

  clean_reminder_timer_if #(.UW(17)) bus  ();
  clean_reminder_timer_if #(.UW(3))  bus2 ();

  clean_reminder_timer #(
    .TICK_DIV(4), .THRESH_SEC(5), .CLEAN_SEC(3), .UW(17)
`ifdef CLEAN_REMINDER_SNOOZE_EN
    , .SNOOZE_SEC(2)
`endif
  ) dut (
    .clk_500Hz (clk_500Hz),
    .rst_n     (rst_n),
    .bus       (bus.slave)
  );

  clean_reminder_timer #(
    .TICK_DIV(4), .THRESH_SEC(5), .CLEAN_SEC(3), .UW(3)
`ifdef CLEAN_REMINDER_SNOOZE_EN
    , .SNOOZE_SEC(2)
`endif
  ) dut_sat (
    .clk_500Hz (clk_500Hz),
    .rst_n     (rst_n),
    .bus       (bus2.slave)
  );

  typedef struct {
    logic fan; logic ca; int n;
    int w; int b; int u; int l; int w2; int u2;
  } vec_t;

  typedef struct {
    int w; int b; int u; int l; int w2; int u2;
  } exp_t;

  vec_t vecs[25];
  exp_t sb[$];
  exp_t e;

  task automatic step(input int n);
    repeat (n) @(posedge clk_500Hz);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, req);
    end
  endtask

  initial begin
    // fan, clean_active, cycles | warning, busy, usage, left | sat warning, sat usage
    vecs[0]  = '{1'b0, 1'b0,  0, 0, 0, 0, 0, 0, 0};
    vecs[1]  = '{1'b1, 1'b0,  4, 0, 0, 1, 0, 0, 1};
    vecs[2]  = '{1'b1, 1'b0, 15, 0, 0, 4, 0, 0, 4};
    vecs[3]  = '{1'b1, 1'b0,  1, 0, 0, 5, 0, 0, 5};
    vecs[4]  = '{1'b1, 1'b0,  1, 1, 0, 5, 0, 1, 5};
    vecs[5]  = '{1'b0, 1'b0,  8, 1, 0, 5, 0, 1, 7};
    vecs[6]  = '{1'b0, 1'b1,  1, 0, 1, 5, 3, 1, 7};
    vecs[7]  = '{1'b0, 1'b1,  2, 0, 1, 5, 2, 1, 7};
    vecs[8]  = '{1'b0, 1'b1,  4, 0, 1, 5, 1, 1, 7};
    vecs[9]  = '{1'b0, 1'b1,  3, 0, 1, 5, 1, 1, 7};
    vecs[10] = '{1'b0, 1'b1,  1, 0, 0, 0, 0, 1, 7};
    vecs[11] = '{1'b0, 1'b0,  4, 0, 0, 0, 0, 1, 7};
    vecs[12] = '{1'b1, 1'b0, 20, 0, 0, 5, 0, 1, 7};
    vecs[13] = '{1'b1, 1'b0,  1, 1, 0, 5, 0, 1, 7};
    vecs[14] = '{1'b1, 1'b1,  1, 0, 1, 5, 3, 1, 7};
    vecs[15] = '{1'b1, 1'b1,  2, 0, 1, 5, 2, 1, 7};
    vecs[16] = '{1'b1, 1'b0,  1, 1, 0, 5, 0, 1, 7};
    vecs[17] = '{1'b1, 1'b0,  3, 1, 0, 6, 0, 1, 7};
    vecs[18] = '{1'b0, 1'b1,  1, 0, 1, 6, 3, 1, 7};
    vecs[19] = '{1'b0, 1'b1, 10, 0, 1, 6, 1, 1, 7};
    vecs[20] = '{1'b0, 1'b0,  1, 0, 0, 0, 0, 1, 7};
    vecs[21] = '{1'b0, 1'b0,  5, 0, 0, 0, 0, 1, 7};
    vecs[22] = '{1'b1, 1'b0,  3, 0, 0, 1, 0, 1, 7};
    vecs[23] = '{1'b1, 1'b1,  1, 0, 1, 1, 3, 1, 7};
    vecs[24] = '{1'b1, 1'b0,  1, 0, 0, 1, 0, 1, 7};

    bus.fan_on        = 1'b0;
    bus.clean_active  = 1'b0;
    bus2.fan_on       = 1'b1;
    bus2.clean_active = 1'b0;
`ifdef CLEAN_REMINDER_SNOOZE_EN
    bus.snooze        = 1'b0;
    bus2.snooze       = 1'b0;
`endif

    step(3);
    chk("reset warning", int'(bus.warning), 0);
    chk("reset busy",    int'(bus.clean_busy), 0);
    chk("reset usage",   int'(bus.usage_sec), 0);
    chk("reset left",    int'(bus.clean_left), 0);

    @(negedge clk_500Hz);
    rst_n = 1'b1;

    for (int i = 0; i < 25; i++) begin
      bus.fan_on       = vecs[i].fan;
      bus.clean_active = vecs[i].ca;
      sb.push_back('{vecs[i].w, vecs[i].b, vecs[i].u, vecs[i].l, vecs[i].w2, vecs[i].u2});
      step(vecs[i].n);
      e = sb.pop_front();
      chk($sformatf("vec%0d warning", i),     int'(bus.warning),    e.w);
      chk($sformatf("vec%0d busy", i),        int'(bus.clean_busy), e.b);
      chk($sformatf("vec%0d usage", i),       int'(bus.usage_sec),  e.u);
      chk($sformatf("vec%0d left", i),        int'(bus.clean_left), e.l);
      chk($sformatf("vec%0d sat warning", i), int'(bus2.warning),   e.w2);
      chk($sformatf("vec%0d sat usage", i),   int'(bus2.usage_sec), e.u2);
    end

    // Asynchronous reset in the middle of a clean, between clock edges.
    bus.clean_active = 1'b1;
    step(1);
    chk("preclean busy", int'(bus.clean_busy), 1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async rst warning",   int'(bus.warning),    0);
    chk("async rst busy",      int'(bus.clean_busy), 0);
    chk("async rst usage",     int'(bus.usage_sec),  0);
    chk("async rst left",      int'(bus.clean_left), 0);
    chk("async rst sat usage", int'(bus2.usage_sec), 0);
    chk("async rst sat warn",  int'(bus2.warning),   0);
    bus.clean_active = 1'b0;
    bus.fan_on       = 1'b1;
    @(negedge clk_500Hz);
    rst_n = 1'b1;
    step(3);
    chk("restart pre-tick usage", int'(bus.usage_sec), 0);
    step(1);
    chk("restart usage",     int'(bus.usage_sec),  1);
    chk("restart sat usage", int'(bus2.usage_sec), 1);
    step(16);
    chk("restart thresh usage", int'(bus.usage_sec), 5);
    chk("restart thresh warn",  int'(bus.warning),   0);
    step(1);
    chk("restart warn rise", int'(bus.warning), 1);

`ifdef CLEAN_REMINDER_SNOOZE_EN
    bus.snooze = 1'b1;
    step(1);
    bus.snooze = 1'b0;
    chk("snooze warn low", int'(bus.warning),    0);
    chk("snooze not busy", int'(bus.clean_busy), 0);
    step(5);
    chk("snooze mid warn",  int'(bus.warning),   0);
    chk("snooze mid usage", int'(bus.usage_sec), 6);
    step(1);
    chk("snooze end warn",  int'(bus.warning),   1);
    chk("snooze end usage", int'(bus.usage_sec), 7);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
